pio_pattern_sequencer: RTL and testbench

//  Avalon-MM controller that drives an 8-bit PIO output register (s1 data register, offset 0) with a programmed pattern.
//  Up to DEPTH pattern bytes are written to the PIO at a programmable interval, one-shot or looping.

---
 rtl/pio_pattern_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_pio_pattern_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_pattern_sequencer.sv
// Avalon-MM pattern sequencer: streams up to DEPTH programmed bytes into a PIO data register
// at a programmable interval, one-shot or looping, without CPU involvement.
module pio_pattern_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  csr_address,
    input  logic        csr_chipselect,
    input  logic        csr_write_n,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    localparam int unsigned IDX_W = 4;
    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_STATUS = 5'd1;
    localparam logic [4:0] ADDR_PERIOD = 5'd2;
    localparam logic [4:0] ADDR_LENGTH = 5'd3;
    localparam logic [4:0] ADDR_PAT    = 5'd16;

    typedef enum logic [1:0] {StIdle, StWrite, StWait} state_e;

    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic             loop_q, loop_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       length_q;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       pattern_q [DEPTH];

    logic       csr_wr;
    logic       ctrl_wr;
    logic       status_wr;
    logic       pat_hit;
    logic [4:0] pat_off;
    logic [4:0] eff_len;
    logic       last;
    logic       enable_eff;
    logic       unused_bits;

    assign csr_wr    = csr_chipselect & ~csr_write_n;
    assign ctrl_wr   = csr_wr && (csr_address == ADDR_CTRL);
    assign status_wr = csr_wr && (csr_address == ADDR_STATUS);
    assign pat_off   = csr_address - ADDR_PAT;
    assign pat_hit   = (csr_address >= ADDR_PAT) && (pat_off < 5'(DEPTH));
    assign unused_bits = ^csr_writedata[31:CNT_W];

    always_comb begin
        eff_len = length_q;
        if (length_q == 5'd0) begin
            eff_len = 5'd1;
        end else if (length_q > 5'(DEPTH)) begin
            eff_len = 5'(DEPTH);
        end
    end

    // ">=" so that a LENGTH shrunk below the current index still wraps/terminates
    assign last = ({1'b0, index_q} + 5'd1) >= eff_len;
    // A stop written in this very cycle takes effect immediately
    assign enable_eff = ctrl_wr ? csr_writedata[0] : enable_q;

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        loop_d   = loop_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        index_d  = index_q;
        data_d   = data_q;

        if (ctrl_wr) begin
            enable_d = csr_writedata[0];
            loop_d   = csr_writedata[1];
        end
        if (status_wr && csr_writedata[1]) begin
            done_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (ctrl_wr && csr_writedata[0]) begin
                    state_d = StWrite;
                    index_d = '0;
                    done_d  = 1'b0;
                    data_d  = pattern_q[0];
                end
            end
            StWrite: begin
                if (!m_waitrequest) begin
                    if (!enable_eff) begin
                        state_d = StIdle;
                    end else if (last && !loop_d) begin
                        // Completion overrides a same-cycle W1C of done
                        state_d  = StIdle;
                        enable_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = period_q;
                        index_d = last ? '0 : index_q + IDX_W'(1);
                    end
                end
            end
            StWait: begin
                if (!enable_eff) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StWrite;
                    data_d  = pattern_q[index_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            enable_q <= 1'b0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            index_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            length_q <= 5'd1;
            for (int i = 0; i < DEPTH; i++) begin
                pattern_q[i] <= '0;
            end
        end else if (csr_wr) begin
            if (csr_address == ADDR_PERIOD) begin
                period_q <= csr_writedata[CNT_W-1:0];
            end
            if (csr_address == ADDR_LENGTH) begin
                length_q <= csr_writedata[4:0];
            end
            if (pat_hit) begin
                pattern_q[pat_off[IDX_W-1:0]] <= csr_writedata[7:0];
            end
        end
    end

    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            ADDR_CTRL:   csr_readdata[1:0] = {loop_q, enable_q};
            ADDR_STATUS: begin
                csr_readdata[0]    = (state_q != StIdle);
                csr_readdata[1]    = done_q;
                csr_readdata[11:8] = index_q;
            end
            ADDR_PERIOD: csr_readdata[CNT_W-1:0] = period_q;
            ADDR_LENGTH: csr_readdata[4:0] = length_q;
            default: begin
                if (pat_hit) begin
                    csr_readdata[7:0] = pattern_q[pat_off[IDX_W-1:0]];
                end
            end
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = (state_q == StWrite);
    assign m_write_n    = ~m_chipselect;
    assign m_writedata  = {24'h0, data_q};

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Bench for pio_pattern_sequencer: expected PIO writes (data and spacing) go into a queue when a
// sequence is launched and are popped by a monitor as the DUT performs them.
module tb_pio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write_n = 1'b1;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;

    always #5 clk = ~clk;

    pio_pattern_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write_n    (csr_write_n),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .m_address      (m_address),
        .m_chipselect   (m_chipselect),
        .m_write_n      (m_write_n),
        .m_writedata    (m_writedata),
        .m_waitrequest  (m_waitrequest)
    );

    typedef struct {
        logic [7:0] data;
        int         gap;  // cycles since previous write; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errs = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && m_chipselect && !m_waitrequest) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_write", m_writedata, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pio_data", m_writedata, {24'h0, mon_e.data});
                check_eq("pio_write_n", 32'(m_write_n), 32'd0);
                if (mon_e.gap != 0) begin
                    check_eq("pio_gap", cyc - last_cyc, mon_e.gap);
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
        csr_address    = a;
        csr_writedata  = d;
        csr_chipselect = 1'b1;
        csr_write_n    = 1'b0;
        tick();
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
    endtask

    task automatic csr_rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        csr_address = a;
        #1;
        check_eq(tag, csr_readdata, exp);
        tick();
    endtask

    task automatic start(input logic [31:0] ctrl);
        last_cyc = cyc;
        csr_wr(5'd0, ctrl);
    endtask

    task automatic push(input logic [7:0] d, input int gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cs", 32'(m_chipselect), 32'd0);
        check_eq("rst_write_n", 32'(m_write_n), 32'd1);
        check_eq("rst_addr", 32'(m_address), 32'd0);
        check_eq("rst_wdata", m_writedata, 32'd0);
        reset_n = 1'b1;
        tick();
        csr_rd_check("rst_ctrl", 5'd0, 32'h0);
        csr_rd_check("rst_status", 5'd1, 32'h0);
        csr_rd_check("rst_period", 5'd2, 32'h0);
        csr_rd_check("rst_length", 5'd3, 32'h1);
        csr_rd_check("rst_pat31", 5'd31, 32'h0);

        // One-shot, four bytes, PERIOD=3
        csr_wr(5'd16, 32'h01);
        csr_wr(5'd17, 32'h02);
        csr_wr(5'd18, 32'h04);
        csr_wr(5'd19, 32'h08);
        csr_wr(5'd3, 32'd4);
        csr_wr(5'd2, 32'd3);
        csr_rd_check("t2_pat2", 5'd18, 32'h04);
        push(8'h01, 1);
        push(8'h02, 5);
        push(8'h04, 5);
        push(8'h08, 5);
        start(32'h1);
        drain("t2_drain");
        idle(6);
        csr_rd_check("t2_status", 5'd1, 32'h302);
        csr_rd_check("t2_ctrl", 5'd0, 32'h0);

        // Loop, three bytes, PERIOD=0, stop during WAIT
        csr_wr(5'd3, 32'd3);
        csr_wr(5'd2, 32'd0);
        push(8'h01, 1);
        for (int i = 1; i < 7; i++) push(pat(0) ^ pat(0) | (8'h01 << (i % 3)), 2);
        start(32'h3);
        drain("t3_drain");
        csr_wr(5'd0, 32'h0);
        check_eq("t3_stop_cs", 32'(m_chipselect), 32'd0);
        csr_rd_check("t3_status", 5'd1, 32'h100);
        idle(4);

        // Stall for 5 cycles with a stop issued mid-stall
        csr_wr(5'd16, 32'hA5);
        csr_wr(5'd17, 32'h5A);
        csr_wr(5'd3, 32'd2);
        csr_wr(5'd2, 32'd1);
        m_waitrequest = 1'b1;
        push(8'hA5, 0);
        start(32'h1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                csr_address    = 5'd0;
                csr_writedata  = 32'h0;
                csr_chipselect = 1'b1;
                csr_write_n    = 1'b0;
            end
            if (i == 3) begin
                csr_chipselect = 1'b0;
                csr_write_n    = 1'b1;
            end
            if (i == 5) m_waitrequest = 1'b0;
            check_eq("t4_strobe", {30'b0, m_chipselect, m_write_n}, 32'h2);
            check_eq("t4_data", m_writedata, 32'hA5);
            tick();
        end
        drain("t4_drain");
        check_eq("t4_idle_cs", 32'(m_chipselect), 32'd0);
        csr_rd_check("t4_status", 5'd1, 32'h0);
        idle(5);

        // LENGTH=0 behaves as a single entry
        csr_wr(5'd3, 32'd0);
        push(8'hA5, 1);
        start(32'h1);
        drain("t5a_drain");
        idle(6);
        csr_rd_check("t5a_status", 5'd1, 32'h002);

        // LENGTH=31 clamps to DEPTH
        for (int i = 0; i < 16; i++) csr_wr(5'(16 + i), {24'h0, pat(i)});
        csr_wr(5'd3, 32'd31);
        csr_wr(5'd2, 32'd0);
        for (int i = 0; i < 16; i++) push(pat(i), (i == 0) ? 1 : 2);
        start(32'h1);
        drain("t5b_drain");
        idle(4);
        csr_rd_check("t5b_status", 5'd1, 32'hF02);
        csr_rd_check("t5b_length", 5'd3, 32'h1F);

        // Maximum PERIOD: no second write within a long window
        csr_wr(5'd2, 32'hFFFF_FFFF);
        csr_rd_check("t5c_period", 5'd2, 32'h00FF_FFFF);
        csr_wr(5'd3, 32'd2);
        push(pat(0), 1);
        start(32'h1);
        drain("t5c_drain");
        idle(200);
        csr_rd_check("t5c_busy", 5'd1, 32'h101);
        csr_wr(5'd0, 32'h0);
        csr_rd_check("t5c_stopped", 5'd1, 32'h100);

        // Pattern rewrite during WAIT is picked up at the next fetch
        csr_wr(5'd16, 32'h11);
        csr_wr(5'd17, 32'h22);
        csr_wr(5'd2, 32'd20);
        push(8'h11, 1);
        start(32'h1);
        drain("t6_drain1");
        push(8'h99, 22);
        csr_wr(5'd17, 32'h99);
        drain("t6_drain2");
        idle(4);
        csr_rd_check("t6_status", 5'd1, 32'h102);

        // W1C in the completion cycle loses to completion
        csr_wr(5'd3, 32'd1);
        csr_wr(5'd2, 32'd5);
        push(8'h11, 1);
        start(32'h1);
        csr_wr(5'd1, 32'h2);
        drain("t6_drain3");
        idle(3);
        csr_rd_check("t6_w1c_race", 5'd1, 32'h002);
        csr_wr(5'd1, 32'h2);
        csr_rd_check("t6_w1c", 5'd1, 32'h000);

        // Asynchronous reset in the middle of a stalled write
        m_waitrequest = 1'b1;
        start(32'h1);
        check_eq("t1_cs_before", 32'(m_chipselect), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t1_cs_async", 32'(m_chipselect), 32'd0);
        check_eq("t1_write_n_async", 32'(m_write_n), 32'd1);
        m_waitrequest = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        csr_rd_check("t1_length", 5'd3, 32'h1);
        csr_rd_check("t1_period", 5'd2, 32'h0);
        csr_rd_check("t1_ctrl", 5'd0, 32'h0);
        csr_rd_check("t1_status", 5'd1, 32'h0);
        csr_rd_check("t1_pat0", 5'd16, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
